// File: rtl/gb_seq_pkg.sv
// Shared types and default widths for the gbprocessor instruction sequencer.
package gb_seq_pkg;

    localparam int GB_INSTR_W = 8;
    localparam int GB_PROBE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gb_instr_fifo.sv
// Power-of-two instruction FIFO; head is the oldest entry, pushes while full are dropped.
module gb_instr_fifo
    import gb_seq_pkg::*;
#(
    parameter int INSTR_W = GB_INSTR_W,
    parameter int DEPTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [INSTR_W-1:0]     wdata_i,
    input  logic                   pop_i,
    output logic [INSTR_W-1:0]     head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gb_instr_sequencer.sv
// Buffers host instructions, issues them to the gbprocessor core one at a time with a
// minimum spacing, and returns the probe sampled PROBE_LAT cycles after each issue.
module gb_instr_sequencer
    import gb_seq_pkg::*;
#(
    parameter int INSTR_W   = GB_INSTR_W,
    parameter int PROBE_W   = GB_PROBE_W,
    parameter int DEPTH     = 8,
    parameter int ISSUE_GAP = 1,
    parameter int PROBE_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [INSTR_W-1:0]     cpu_instruction,
    output logic                   cpu_valid,
    input  logic [PROBE_W-1:0]     cpu_probe,
    output logic [INSTR_W-1:0]     res_instr,
    output logic [PROBE_W-1:0]     res_probe,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int WW = (PROBE_LAT > 1) ? $clog2(PROBE_LAT) : 1;
    localparam logic [GW-1:0] GAP_LOAD  = GW'(ISSUE_GAP - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(PROBE_LAT - 1);

    seq_state_t             state_q;
    logic                   cpu_valid_q;
    logic [INSTR_W-1:0]     cpu_instr_q;
    logic                   res_valid_q;
    logic [INSTR_W-1:0]     res_instr_q;
    logic [PROBE_W-1:0]     res_probe_q;
    logic [GW-1:0]          gap_q;
    logic [WW-1:0]          wait_q;

    logic [INSTR_W-1:0]     fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_pop;

    // The FIFO entry is consumed at the end of the single ISSUE cycle.
    assign fifo_pop = (state_q == ISSUE);

    gb_instr_fifo #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (in_valid),
        .wdata_i (in_instr),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_valid_q <= 1'b0;
            cpu_instr_q <= '0;
            res_valid_q <= 1'b0;
            res_instr_q <= '0;
            res_probe_q <= '0;
            gap_q       <= '0;
            wait_q      <= '0;
        end else begin
            cpu_valid_q <= 1'b0;
            if (gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
            case (state_q)
                IDLE: begin
                    // Gap is loaded on entry to ISSUE so pulses are exactly ISSUE_GAP apart at best.
                    if (enable && !fifo_empty && (gap_q == '0)) begin
                        state_q     <= ISSUE;
                        cpu_valid_q <= 1'b1;
                        cpu_instr_q <= fifo_head;
                        gap_q       <= GAP_LOAD;
                    end
                end
                ISSUE: begin
                    res_instr_q <= cpu_instr_q;
                    wait_q      <= WAIT_LOAD;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        res_probe_q <= cpu_probe;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready        = !fifo_full;
    assign cpu_instruction = cpu_instr_q;
    assign cpu_valid       = cpu_valid_q;
    assign res_instr       = res_instr_q;
    assign res_probe       = res_probe_q;
    assign res_valid       = res_valid_q;
    assign count           = fifo_count;
    assign busy            = (state_q != IDLE) || (fifo_count != '0);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Bench for gb_instr_sequencer: latency vectors, reset, overflow, back-pressure, push/pop and spacing.
module tb_gb_instr_sequencer;
    import gb_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main instance: default parameters
    logic       enable, in_valid, in_ready, cpu_valid, res_valid, res_ready, busy;
    logic [7:0] in_instr, cpu_instruction, cpu_probe, res_instr, res_probe;
    logic [3:0] count;
    logic [1:0] dbg_state;

    // spacing instance: ISSUE_GAP=8
    logic       g_enable, g_in_valid, g_in_ready, g_cpu_valid, g_res_valid, g_res_ready, g_busy;
    logic [7:0] g_in_instr, g_cpu_instruction, g_cpu_probe, g_res_instr, g_res_probe;
    logic [3:0] g_count;
    logic [1:0] g_dbg_state;

    gb_instr_sequencer u_dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_instruction(cpu_instruction), .cpu_valid(cpu_valid), .cpu_probe(cpu_probe),
        .res_instr(res_instr), .res_probe(res_probe), .res_valid(res_valid), .res_ready(res_ready),
        .count(count), .busy(busy), .dbg_state(dbg_state)
    );

    gb_instr_sequencer #(.ISSUE_GAP(8), .PROBE_LAT(1)) u_gap (
        .clock(clock), .reset(reset), .enable(g_enable),
        .in_instr(g_in_instr), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .cpu_instruction(g_cpu_instruction), .cpu_valid(g_cpu_valid), .cpu_probe(g_cpu_probe),
        .res_instr(g_res_instr), .res_probe(g_res_probe), .res_valid(g_res_valid), .res_ready(g_res_ready),
        .count(g_count), .busy(g_busy), .dbg_state(g_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks;
    int          n_fail;
    int          n_res;
    logic [7:0]  exp_instr_q[$];
    logic [15:0] exp_q[$];
    logic        pend_valid;
    logic [7:0]  pend_instr;
    logic [15:0] sb_e;
    logic        probe_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A free-running probe makes the sampling instant observable.
    always @(posedge clock) begin
        #1;
        if (probe_run) cpu_probe = cpu_probe + 8'h1D;
    end

    // Issue order comes from the push order; the expected probe is whatever the
    // core drives in the cycle after the issue cycle (PROBE_LAT=1).
    always @(negedge clock) begin
        if (!reset) begin
            if (pend_valid) begin
                exp_q.push_back({pend_instr, cpu_probe});
                pend_valid = 1'b0;
            end
            if (cpu_valid) begin
                check("issue_expected", exp_instr_q.size() != 0, 1);
                if (exp_instr_q.size() != 0) check("issue_order", cpu_instruction, exp_instr_q.pop_front());
                pend_valid = 1'b1;
                pend_instr = cpu_instruction;
            end
            if (res_valid && res_ready) begin
                check("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    sb_e = exp_q.pop_front();
                    check("res_instr", res_instr, sb_e[15:8]);
                    check("res_probe", res_probe, sb_e[7:0]);
                end
                n_res++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [7:0] w);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        check("push_wait_ready", in_ready, 1);
        in_instr = w;
        in_valid = 1'b1;
        exp_instr_q.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int t;
        t = 0;
        while (n_res < target && t < 300) begin
            tick();
            t++;
        end
        check("drain_results", n_res, target);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] instr;
        logic [7:0] probe;
        logic [7:0] exp_instr;
        logic [7:0] exp_probe;
        int         exp_issue;
        int         exp_res;
    } vec_t;
    vec_t vecs[5];

    int         issue_cyc, res_cyc, base, n_pulse, t, diff;
    logic       held;
    logic [7:0] r_i, r_p, cap_i, cap_p;
    int         g_p[$];
    logic [7:0] g_ins[$];

    initial begin
        vecs[0] = '{8'h3E, 8'h5A, 8'h3E, 8'h5A, 1, 3};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 1, 3};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 1, 3};
        vecs[3] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 1, 3};
        vecs[4] = '{8'h81, 8'h7E, 8'h81, 8'h7E, 1, 3};

        n_checks = 0; n_fail = 0; n_res = 0; pend_valid = 1'b0; probe_run = 1'b0;
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_instr = 8'h00; cpu_probe = 8'h00; res_ready = 1'b1;
        g_enable = 1'b0; g_in_valid = 1'b0; g_in_instr = 8'h00; g_cpu_probe = 8'hC3; g_res_ready = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_cpu_valid", cpu_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_cpu_instruction", cpu_instruction, 0);
        check("rst_res_instr", res_instr, 0);
        check("rst_res_probe", res_probe, 0);
        reset = 1'b0;
        enable = 1'b1;
        tick();

        // single-instruction latency, PROBE_LAT=1
        for (int v = 0; v < 5; v++) begin
            cpu_probe = vecs[v].probe;
            in_instr = vecs[v].instr;
            in_valid = 1'b1;
            exp_instr_q.push_back(vecs[v].instr);
            tick();
            in_valid = 1'b0;
            issue_cyc = -1; res_cyc = -1; r_i = 8'h00; r_p = 8'h00;
            for (int c = 1; c <= 8; c++) begin
                tick();
                if (cpu_valid && issue_cyc < 0) issue_cyc = c;
                if (res_valid && res_cyc < 0) begin
                    res_cyc = c;
                    r_i = res_instr;
                    r_p = res_probe;
                end
            end
            check("vec_issue_cycle", issue_cyc, vecs[v].exp_issue);
            check("vec_res_cycle", res_cyc, vecs[v].exp_res);
            check("vec_res_instr", r_i, vecs[v].exp_instr);
            check("vec_res_probe", r_p, vecs[v].exp_probe);
            check("vec_cpu_instr_held", cpu_instruction, vecs[v].exp_instr);
            check("vec_idle_busy", busy, 0);
        end

        // reset asserted mid-WAIT drops the in-flight instruction
        base = n_res;
        in_instr = 8'h3E;
        in_valid = 1'b1;
        exp_instr_q.push_back(8'h3E);
        tick();
        in_valid = 1'b0;
        tick();
        check("rw_issue", cpu_valid, 1);
        tick();
        check("rw_in_wait", dbg_state, WAIT);
        check("rw_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rw_cpu_valid", cpu_valid, 0);
        check("rw_res_valid", res_valid, 0);
        check("rw_count", count, 0);
        check("rw_busy", busy, 0);
        check("rw_cpu_instruction", cpu_instruction, 0);
        check("rw_state", dbg_state, IDLE);
        pend_valid = 1'b0;
        exp_q.delete();
        exp_instr_q.delete();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("rw_no_result", n_res, base);

        // fill to DEPTH with enable low, then drain in order
        base = n_res;
        enable = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in_instr = 8'(i);
            in_valid = 1'b1;
            check("ovf_in_ready", in_ready, (i <= 8));
            if (i <= 8) exp_instr_q.push_back(8'(i));
            tick();
        end
        check("ovf_count_full", count, 8);
        check("ovf_in_ready_low", in_ready, 0);
        tick();
        check("ovf_count_hold", count, 8);
        enable = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("ovf_ready_returns", in_ready, 1);
        exp_instr_q.push_back(8'h09);
        tick();
        in_valid = 1'b0;
        wait_results(base + 9);
        check("ovf_drained", count, 0);

        // result back-pressure
        base = n_res;
        enable = 1'b0;
        res_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        probe_run = 1'b1;
        enable = 1'b1;
        n_pulse = 0; held = 1'b0; cap_i = 8'h00; cap_p = 8'h00;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (cpu_valid) n_pulse++;
            if (held) begin
                check("bp_res_valid_high", res_valid, 1);
                check("bp_res_instr_stable", res_instr, cap_i);
                check("bp_res_probe_stable", res_probe, cap_p);
            end else if (res_valid) begin
                held = 1'b1;
                cap_i = res_instr;
                cap_p = res_probe;
            end
        end
        check("bp_one_pulse", n_pulse, 1);
        check("bp_result_seen", held, 1);
        check("bp_count", count, 2);
        res_ready = 1'b1;
        wait_results(base + 3);
        probe_run = 1'b0;

        // push on the ISSUE edge at count=3
        base = n_res;
        enable = 1'b0;
        push_word(8'h41);
        push_word(8'h42);
        push_word(8'h43);
        check("pp_count_start", count, 3);
        enable = 1'b1;
        t = 0;
        tick();
        while (!cpu_valid && t < 20) begin
            tick();
            t++;
        end
        check("pp_issue_seen", cpu_valid, 1);
        check("pp_count_issue", count, 3);
        in_instr = 8'h77;
        in_valid = 1'b1;
        exp_instr_q.push_back(8'h77);
        tick();
        in_valid = 1'b0;
        check("pp_count_after", count, 3);
        wait_results(base + 4);

        // issue spacing on the ISSUE_GAP=8 instance
        g_in_valid = 1'b1;
        g_in_instr = 8'hA1;
        tick();
        g_in_instr = 8'hB2;
        tick();
        g_in_valid = 1'b0;
        g_enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (g_cpu_valid) begin
                g_p.push_back(c);
                g_ins.push_back(g_cpu_instruction);
            end
        end
        check("gap_pulse_count", g_p.size(), 2);
        diff = (g_p.size() >= 2) ? (g_p[1] - g_p[0]) : -1;
        check("gap_spacing", diff, 8);
        check("gap_first_instr", (g_ins.size() >= 1) ? g_ins[0] : 8'h00, 8'hA1);
        check("gap_second_instr", (g_ins.size() >= 2) ? g_ins[1] : 8'h00, 8'hB2);

        // ---------------- final report ----------------
        check("sb_issue_queue_empty", exp_instr_q.size(), 0);
        check("sb_result_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/gb_instr_sequencer.md
Name: gb_instr_sequencer

Overview:
- Parametrised instruction issue engine between a host-side stream and the gbprocessor core.
- Buffers instructions in a FIFO and drives the core's `instruction`/`valid` pair, one instruction at a time, with a programmable minimum issue spacing.
- Samples the core's `probe` a fixed latency after each issue and returns it paired with its instruction over a valid/ready result port.
- Replaces hand-driven `instruction`/`valid` pulses in the top-level with a reusable, back-pressured block.

Parameters:
- INSTR_W, 8, width of an instruction word.
- PROBE_W, 8, width of the core probe bus.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ISSUE_GAP, 1, minimum cycles between consecutive cpu_valid pulses (≥1).
- PROBE_LAT, 1, cycles after the issue cycle at which probe is sampled (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting new issues.
- in_instr  in  INSTR_W  instruction to enqueue.
- in_valid  in  1  in_instr valid.
- in_ready  out  1  FIFO can accept (= not full).
- cpu_instruction  out  INSTR_W  to core `instruction`.
- cpu_valid  out  1  to core `valid`; one-cycle pulse per instruction.
- cpu_probe  in  PROBE_W  from core `probe`.
- res_instr  out  INSTR_W  instruction whose result is presented.
- res_probe  out  PROBE_W  sampled probe value.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  state != IDLE or count != 0.

Behaviour:
- Cycle N denotes the cycle following rising edge N.
- Reset (async, any time) forces:
  - cpu_valid=0, res_valid=0, in_ready=1, count=0, busy=0.
  - cpu_instruction, res_instr and res_probe = 0.
  - state=IDLE, gap counter=0.
  - An in-flight instruction is dropped; no result is produced for it.
- FIFO:
  - Push on an edge with in_valid && in_ready.
  - Pop in the ISSUE cycle.
  - Push and pop on the same edge are both honoured (count unchanged).
  - in_ready = !full, computed from the current count; a pop in the same cycle does not raise it.
  - Pointers wrap modulo DEPTH.
  - A push while full is ignored; the upstream must hold it.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE -> ISSUE when enable && count!=0 && gap counter==0.
  - ISSUE:
    - cpu_valid=1 and cpu_instruction=FIFO head for exactly one cycle.
    - Pop the FIFO and latch head into res_instr.
    - Load gap counter with ISSUE_GAP-1 and wait counter with PROBE_LAT-1.
    - -> WAIT.
  - WAIT:
    - Decrement the wait counter each cycle.
    - In the cycle it reads 0, sample cpu_probe into res_probe at the end edge, then -> HOLD.
  - HOLD:
    - res_valid=1; res_instr and res_probe stay stable.
    - On an edge with res_ready -> IDLE, with res_valid low next cycle.
- Gap counter decrements every cycle while nonzero, saturating at 0.
- cpu_instruction is held at its last value when cpu_valid=0.
- Latency (empty FIFO, enable=1, ISSUE_GAP met, res_ready=1):
  - Push at edge 0 -> cpu_valid in cycle 1.
  - res_valid in cycle 2+PROBE_LAT.
  - Next issue in cycle 4+PROBE_LAT or later.
- Dropping enable does not abort an in-flight instruction; it only blocks IDLE->ISSUE.
- Back-pressure: no new issue occurs while HOLD waits on res_ready; the FIFO keeps accepting until full.

Decomposition:
- Package gb_seq_pkg holds:
  - State enum seq_state_t (IDLE, ISSUE, WAIT, HOLD).
  - Default width constants GB_INSTR_W=8 and GB_PROBE_W=8.
- Sub-module gb_instr_fifo (parametrised INSTR_W, DEPTH; sync push/pop, async reset) provides head, full, empty and count.
- The FSM, counters and result registers live in the top of this block.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: push 0x3E, assert reset at cycle 2.
  - Response: cpu_valid, res_valid and count go to 0 immediately; no result is ever produced for 0x3E.
- Single instruction, PROBE_LAT=1:
  - Stimulus: push 0x3E at edge 0; core probe=0x5A.
  - Response: cpu_valid in cycle 1 with 0x3E; res_valid in cycle 3 with res_instr=0x3E, res_probe=0x5A.
- Fill and overflow, DEPTH=8:
  - Stimulus: push 9 words 0x01..0x09 with enable=0.
  - Response: in_ready=0 after the 8th push, count=8; 0x09 stays pending; after enable=1, issue order is 0x01..0x09.
- Result back-pressure:
  - Stimulus: hold res_ready=0 for 10 cycles with 3 words queued.
  - Response: exactly one cpu_valid pulse; res_valid stays high with stable data; the next issue occurs only after res_ready.
- Issue spacing, ISSUE_GAP=8, PROBE_LAT=1:
  - Stimulus: 2 queued instructions, res_ready=1.
  - Response: cpu_valid pulses exactly 8 cycles apart, not 5.
- Simultaneous push/pop at count=3:
  - Stimulus: push in the ISSUE cycle.
  - Response: count stays 3; the pushed word is issued after the existing two.
